// File: rtl/axi_wdata_streamer.sv
// AXI W-channel streamer: pops a show-ahead FIFO into mb_w*mb_h bursts of BURST_LEN beats.
// Optional stall counter output enabled by defining AXI_WDATA_STREAMER_STALL_CNT_EN.
module axi_wdata_streamer #(
  parameter int DATA_W    = 1024,
  parameter int BURST_LEN = 7,
  parameter int DIM_W     = 11
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_pulse,
  input  logic [31:0]         mb_w,
  input  logic [31:0]         mb_h,
  input  logic                fifo_empty,
  input  logic [DATA_W-1:0]   fifo_dout,
  output logic                fifo_rd,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  output logic                m_axi_wlast,
  input  logic                m_axi_wready,
  output logic                busy,
  output logic                done_pulse
`ifdef AXI_WDATA_STREAMER_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt
`endif
);

  localparam int MB_W   = 2 * DIM_W;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {IDLE, INIT, SEND, DONE} state_t;

  state_t            state, state_nxt;
  logic [MB_W-1:0]   mb_total, mb_cnt, mb_prod;
  logic [BEAT_W-1:0] beat_cnt;
  logic              hs, last_beat, last_mb;
  logic              unused_dims;

  // Only the low DIM_W bits of each dimension take part in the product.
  assign unused_dims = ^{mb_w[31:DIM_W], mb_h[31:DIM_W]};
  assign mb_prod     = MB_W'(mb_w[DIM_W-1:0]) * MB_W'(mb_h[DIM_W-1:0]);

  assign m_axi_wvalid = (state == SEND) && !fifo_empty;
  assign hs           = m_axi_wvalid && m_axi_wready;
  assign fifo_rd      = hs;
  assign m_axi_wdata  = fifo_dout;
  assign m_axi_wstrb  = '1;
  assign last_beat    = (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign last_mb      = (mb_cnt == mb_total - MB_W'(1));
  assign m_axi_wlast  = m_axi_wvalid && last_beat;
  assign busy         = (state != IDLE);
  assign done_pulse   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_pulse) state_nxt = INIT;
      INIT:    state_nxt = (mb_prod == '0) ? DONE : SEND;
      SEND:    if (hs && last_beat && last_mb) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mb_total <= '0;
      mb_cnt   <= '0;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) begin
        mb_total <= mb_prod;
        mb_cnt   <= '0;
        beat_cnt <= '0;
      end else if (hs) begin
        if (last_beat) begin
          beat_cnt <= '0;
          mb_cnt   <= mb_cnt + MB_W'(1);
        end else begin
          beat_cnt <= beat_cnt + BEAT_W'(1);
        end
      end
    end
  end

`ifdef AXI_WDATA_STREAMER_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (state == IDLE && start_pulse) begin
      stall_cnt <= '0;
    end else if (state == SEND && !hs && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_wdata_streamer.sv
// Randomized bench for axi_wdata_streamer, checked every cycle against a beat-count model.
module tb_axi_wdata_streamer;
  localparam int DW   = 64;
  localparam int BL   = 7;
  localparam int DIMW = 11;
  localparam logic [DW/8-1:0] STRB_ONES = '1;

  logic          clk = 1'b0, rst_n = 1'b0, start_pulse = 1'b0, fifo_empty = 1'b1, m_axi_wready = 1'b0;
  logic [31:0]   mb_w = '0, mb_h = '0;
  logic [DW-1:0] fifo_dout = '0;
  logic          fifo_rd, m_axi_wvalid, m_axi_wlast, busy, done_pulse;
  logic [DW-1:0] m_axi_wdata;
  logic [DW/8-1:0] m_axi_wstrb;
`ifdef AXI_WDATA_STREAMER_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  axi_wdata_streamer #(.DATA_W(DW), .BURST_LEN(BL), .DIM_W(DIMW)) dut (
    .clk(clk), .rst_n(rst_n), .start_pulse(start_pulse), .mb_w(mb_w), .mb_h(mb_h),
    .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd(fifo_rd),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wlast(m_axi_wlast), .m_axi_wready(m_axi_wready), .busy(busy), .done_pulse(done_pulse)
`ifdef AXI_WDATA_STREAMER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  int vectors = 0, miscompares = 0;
  // model: frame is a number of beats still owed; phases are a few flags
  bit m_init = 0, m_send = 0, m_done = 0;
  int m_total = 0, m_sent = 0, m_pops = 0;
  longint unsigned m_stall = 0;
  int fifo_head = 0, cyc = 0;
  int n_rd, n_last, n_done, n_valid, first_valid_cyc, done_cyc, last_rd_cyc;

  function automatic logic [63:0] word(input int k);
    return {32'(k) * 32'h9E3779B1, 32'(k) ^ 32'hA5A50F0F};
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input bit st, input bit rdy, input bit emp);
    logic exp_v, exp_l, exp_rd;
    @(negedge clk);
    cyc++;
    start_pulse  = st;
    m_axi_wready = rdy;
    fifo_empty   = emp;
    fifo_dout    = word(fifo_head);
    if (!rst_n) begin
      m_init = 0; m_send = 0; m_done = 0; m_sent = 0; m_stall = 0;
    end
    #1;
    exp_v  = m_send && !emp;
    exp_l  = exp_v && (m_sent % BL == BL - 1);
    exp_rd = exp_v && rdy;
    chk1("busy", busy, m_init | m_send | m_done);
    chk1("done_pulse", done_pulse, m_done);
    chk1("wvalid", m_axi_wvalid, exp_v);
    chk1("wlast", m_axi_wlast, exp_l);
    chk1("fifo_rd", fifo_rd, exp_rd);
    if (exp_v) begin
      chkw("wdata", m_axi_wdata, word(m_pops));
      chkw("wstrb", 64'(m_axi_wstrb), 64'(STRB_ONES));
    end
`ifdef AXI_WDATA_STREAMER_STALL_CNT_EN
    chkw("stall_cnt", 64'(stall_cnt), 64'(m_stall[31:0]));
`endif
    if (fifo_rd === 1'b1) begin n_rd++; last_rd_cyc = cyc; fifo_head++; end
    if (m_axi_wvalid === 1'b1) begin n_valid++; if (first_valid_cyc < 0) first_valid_cyc = cyc; end
    if (m_axi_wlast === 1'b1 && fifo_rd === 1'b1) n_last++;
    if (done_pulse === 1'b1) begin n_done++; done_cyc = cyc; end
    if (rst_n) begin
      if (m_done) m_done = 0;
      else if (m_init) begin
        m_total = (mb_w & ((1 << DIMW) - 1)) * (mb_h & ((1 << DIMW) - 1)) * BL;
        m_sent = 0; m_init = 0;
        if (m_total == 0) m_done = 1; else m_send = 1;
      end else if (m_send) begin
        if (exp_rd) begin
          m_sent++; m_pops++;
          if (m_sent == m_total) begin m_send = 0; m_done = 1; end
        end else if (m_stall != 64'hFFFF_FFFF) m_stall++;
      end else if (st) begin
        m_init = 1; m_stall = 0;
      end
    end
  endtask

  task automatic clear_tallies();
    n_rd = 0; n_last = 0; n_done = 0; n_valid = 0;
    first_valid_cyc = -1; done_cyc = -1; last_rd_cyc = -1;
  endtask

  // mode 0: full FIFO, wready high; 1: random; 2: wready toggles, 5-cycle empty at beat 10; 3: start spam
  task automatic run_frame(input int w, input int h, input int mode, input int stop_at, output int start_cyc);
    int k;
    int empty_left;
    bit emptied, st, rdy, emp;
    k = 0; empty_left = 0; emptied = 0;
    mb_w = w; mb_h = h;
    clear_tallies();
    step(1'b1, 1'b1, 1'b0);
    start_cyc = cyc;
    while ((m_init || m_send || m_done) && k < 5000 && !(stop_at >= 0 && m_sent == stop_at)) begin
      st = 0; rdy = 1; emp = 0;
      case (mode)
        1: begin rdy = ($urandom % 4) != 0; emp = ($urandom % 5) == 0; st = ($urandom % 10) == 0; end
        2: begin
          rdy = cyc[0];
          if (m_sent == 10 && !emptied) begin empty_left = 5; emptied = 1; end
          emp = empty_left > 0;
          if (empty_left > 0) empty_left--;
        end
        3: st = (k % 3) == 0;
        default: ;
      endcase
      step(st, rdy, emp);
      k++;
    end
    if (k >= 5000) begin
      vectors++; miscompares++;
      $display("FAIL frame_timeout: got busy after %0d cycles expected done", k);
    end
  endtask

  initial begin
    int s, w, h;
    rst_n = 1'b0;
    clear_tallies();
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);

    // 2x3 macroblocks, streaming with no back-pressure
    run_frame(2, 3, 0, -1, s);
    chki("s1_rd_count", n_rd, 42);
    chki("s1_wlast_count", n_last, 6);
    chki("s1_done_count", n_done, 1);
    chki("s1_first_valid", first_valid_cyc, s + 2);
    chki("s1_done_after_last", done_cyc, last_rd_cyc + 1);
    chki("s1_contiguous", last_rd_cyc - first_valid_cyc, 41);
`ifdef AXI_WDATA_STREAMER_STALL_CNT_EN
    chki("s1_stall_cnt", int'(stall_cnt), 0);
`endif
    step(1'b0, 1'b1, 1'b0);

    // bit DIM_W of mb_w must be ignored
    run_frame(32'h801, 1, 0, -1, s);
    chki("s2_rd_count", n_rd, 7);
    chki("s2_done_count", n_done, 1);
    step(1'b0, 1'b1, 1'b0);

    // empty frame goes straight to DONE
    run_frame(0, 5, 0, -1, s);
    chki("s3_rd_count", n_rd, 0);
    chki("s3_valid_count", n_valid, 0);
    chki("s3_done_cycle", done_cyc, s + 2);
    step(1'b0, 1'b1, 1'b0);

    // toggling wready with a mid-burst FIFO underrun
    run_frame(2, 3, 2, -1, s);
    chki("s4_rd_count", n_rd, 42);
    chki("s4_wlast_count", n_last, 6);
    step(1'b0, 1'b1, 1'b0);

    // reset at beat 20, then a clean frame
    run_frame(2, 3, 0, 20, s);
    chki("s5_partial_rd", n_rd, 20);
    rst_n = 1'b0;
    clear_tallies();
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chki("s5_reset_rd", n_rd, 0);
    chki("s5_reset_done", n_done, 0);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 1'b0);
    run_frame(2, 3, 0, -1, s);
    chki("s5_refill_rd", n_rd, 42);
    chki("s5_refill_done", n_done, 1);
    step(1'b0, 1'b1, 1'b0);

    // start pulses during SEND are ignored
    run_frame(2, 3, 3, -1, s);
    chki("s6_rd_count", n_rd, 42);
    chki("s6_wlast_count", n_last, 6);
    chki("s6_done_count", n_done, 1);
    step(1'b0, 1'b1, 1'b0);

    // random frames, with junk in the ignored upper dimension bits
    for (int i = 0; i < 8; i++) begin
      w = int'($urandom_range(0, 4) | ($urandom & 32'hFFFF_F800));
      h = int'($urandom_range(0, 3) | ($urandom & 32'hFFFF_F800));
      run_frame(w, h, 1, -1, s);
      chki("rnd_rd_count", n_rd, (w & 32'h7FF) * (h & 32'h7FF) * BL);
      chki("rnd_done_count", n_done, 1);
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) step(1'b0, 1'b1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
